branch_predict_unit: RTL and testbench

- Parametrised successor to the decode-stage branch comparator. It combines a direct-mapped branch target buffer (BTB) and a pattern history table (PHT) of saturating counters.
- Fetch gets a same-cycle taken/target prediction for its PC.
- When the resolve stage supplies the branch type and operands, the unit computes the actual outcome, flags a mispredict with the redirect PC, and trains both tables.
- Sits between the fetch PC mux and the execute/decode resolve point.

---
 rtl/branch_predict_unit_pkg.sv | 16 +
 rtl/branch_outcome.sv | 27 ++
 rtl/branch_predict_unit.sv | 91 +++++++++
 tb/tb_branch_predict_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// branch_predict_unit_pkg: shared types for the branch predictor and the outcome evaluator.
package branch_predict_unit_pkg;
    localparam int XLEN = 64;
    localparam int TAG_W = 10;
    typedef logic [63:0] u64;
    typedef enum logic [2:0] {
        NO_BRANCH, BRANCH_BEQ, BRANCH_BNE, BRANCH_BLT, BRANCH_BGE, BRANCH_BLTU, BRANCH_BGEU, J
    } branch_t;
    typedef enum logic {INIT, RUN} bpu_state_t;
    typedef struct packed {
        logic valid;
        logic jump;
        logic [TAG_W-1:0] tag;
        u64 target;
    } bpu_entry_t;
endpackage

// File: rtl/branch_outcome.sv
// branch_outcome: evaluates actual branch outcome, mispredict flag and correct next PC.
module branch_outcome import branch_predict_unit_pkg::*; #(
    parameter int XLEN = 64
) (
    input  branch_t         branch,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic [XLEN-1:0] target,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    output logic            taken,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc
);
    logic eq, lts, ltu;
    assign eq  = srca == srcb;
    assign lts = $signed(srca) < $signed(srcb);
    assign ltu = srca < srcb;
    assign taken = (branch == BRANCH_BEQ  &  eq) | (branch == BRANCH_BNE  & ~eq)
                 | (branch == BRANCH_BLT  & lts) | (branch == BRANCH_BGE  & ~lts)
                 | (branch == BRANCH_BLTU & ltu) | (branch == BRANCH_BGEU & ~ltu)
                 | (branch == J);
    assign mispredict = (branch != NO_BRANCH)
                      & ((taken != pred_taken) | (taken & (pred_target != target)));
    assign redirect_pc = taken ? target : pc + XLEN'(4);
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB plus saturating-counter PHT with registered resolve feedback.
module branch_predict_unit import branch_predict_unit_pkg::*; #(
    parameter int XLEN = 64,
    parameter int ENTRIES = 64,
    parameter int TAG_W = 10,
    parameter int CTR_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ready,
    input  logic [XLEN-1:0] f_pc,
    output logic            f_pred_taken,
    output logic [XLEN-1:0] f_pred_target,
    input  logic            r_valid,
    input  logic [XLEN-1:0] r_pc,
    input  branch_t         r_branch,
    input  logic [XLEN-1:0] r_srca,
    input  logic [XLEN-1:0] r_srcb,
    input  logic [XLEN-1:0] r_target,
    input  logic            r_pred_taken,
    input  logic [XLEN-1:0] r_pred_target,
    output logic            r_mispredict,
    output logic [XLEN-1:0] r_redirect_pc,
    output logic            r_taken
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] WT = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] WNT = WT - 1'b1;
    typedef struct packed {
        logic valid;
        logic jump;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0] target;
    } entry_t;
    bpu_state_t state, state_nx;
    logic [IDX_W-1:0] cnt, fi, ri;
    logic [TAG_W-1:0] ft, rt;
    entry_t tbl [ENTRIES];
    logic [CTR_W-1:0] ctr [ENTRIES];
    entry_t fe, re;
    logic f_hit, r_hit, fire, train, taken, mispredict;
    logic [XLEN-1:0] redirect_pc;
    assign fi = f_pc[IDX_W+1:2];
    assign ft = f_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign ri = r_pc[IDX_W+1:2];
    assign rt = r_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign ready = state == RUN;
    assign fe = tbl[fi];
    assign re = tbl[ri];
    assign f_hit = ready & fe.valid & (fe.tag == ft);
    assign f_pred_taken = f_hit & (ctr[fi][CTR_W-1] | fe.jump);
    assign f_pred_target = f_pred_taken ? fe.target : f_pc + XLEN'(4);
    assign r_hit = re.valid & (re.tag == rt);
    assign fire = r_valid & (r_branch != NO_BRANCH);
    assign train = fire & ready & ~reset;
    branch_outcome #(.XLEN(XLEN)) u_outcome (
        .branch(r_branch), .pc(r_pc), .srca(r_srca), .srcb(r_srcb), .target(r_target),
        .pred_taken(r_pred_taken), .pred_target(r_pred_target),
        .taken(taken), .mispredict(mispredict), .redirect_pc(redirect_pc)
    );
    always_comb state_nx = (state == INIT && &cnt) ? RUN : state;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            cnt <= '0;
            r_mispredict <= 1'b0;
            r_taken <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            state <= state_nx;
            cnt <= state == INIT ? cnt + 1'b1 : '0;
            r_mispredict <= fire & mispredict;
            r_taken <= fire & taken;
            r_redirect_pc <= fire ? redirect_pc : '0;
        end
    end
    // Tables have no reset of their own; the INIT sweep clears them one entry per cycle.
    always_ff @(posedge clk) begin
        if (state == INIT && !reset) begin
            tbl[cnt].valid <= 1'b0;
            ctr[cnt] <= WNT;
        end else if (train && r_hit) begin
            ctr[ri] <= taken ? (&ctr[ri] ? ctr[ri] : ctr[ri] + 1'b1)
                             : (ctr[ri] == '0 ? ctr[ri] : ctr[ri] - 1'b1);
            if (taken) tbl[ri].target <= r_target;
        end else if (train && taken) begin
            tbl[ri] <= '{valid: 1'b1, jump: r_branch == J, tag: rt, target: r_target};
            ctr[ri] <= WT;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: scoreboard bench for init sweep, training, outcome and mispredict feedback.
module tb_branch_predict_unit;
    import branch_predict_unit_pkg::*;
    logic clk = 0, reset = 1, ready, f_pred_taken, r_valid = 0, r_pred_taken = 0;
    logic r_mispredict, r_taken;
    logic [63:0] f_pc = 0, f_pred_target, r_pc = 0, r_srca = 0, r_srcb = 0, r_target = 0;
    logic [63:0] r_pred_target = 0, r_redirect_pc;
    branch_t r_branch = NO_BRANCH;
    typedef struct {logic fire; logic misp; logic tk; logic [63:0] redir;} exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_err = 0;

    branch_predict_unit dut (
        .clk(clk), .reset(reset), .ready(ready), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
        .f_pred_target(f_pred_target), .r_valid(r_valid), .r_pc(r_pc), .r_branch(r_branch),
        .r_srca(r_srca), .r_srcb(r_srcb), .r_target(r_target), .r_pred_taken(r_pred_taken),
        .r_pred_target(r_pred_target), .r_mispredict(r_mispredict),
        .r_redirect_pc(r_redirect_pc), .r_taken(r_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic model_taken(branch_t b, logic [63:0] a, logic [63:0] c);
        case (b)
            BRANCH_BEQ:  return a == c;
            BRANCH_BNE:  return a != c;
            BRANCH_BLT:  return $signed(a) < $signed(c);
            BRANCH_BGE:  return !($signed(a) < $signed(c));
            BRANCH_BLTU: return a < c;
            BRANCH_BGEU: return a >= c;
            J:           return 1'b1;
            default:     return 1'b0;
        endcase
    endfunction

    task automatic drive_res(input logic [63:0] pc, input branch_t b, input logic [63:0] a,
                             input logic [63:0] c, input logic [63:0] tgt, input logic pt,
                             input logic [63:0] ptgt);
        exp_t e;
        logic t;
        t = model_taken(b, a, c);
        e.fire = b != NO_BRANCH;
        e.tk = e.fire & t;
        e.misp = e.fire & ((t != pt) | (t & (ptgt != tgt)));
        e.redir = t ? tgt : pc + 64'd4;
        sb.push_back(e);
        r_valid = 1; r_pc = pc; r_branch = b; r_srca = a; r_srcb = c;
        r_target = tgt; r_pred_taken = pt; r_pred_target = ptgt;
    endtask

    task automatic check_res(input string tag);
        exp_t e;
        r_valid = 0;
        r_branch = NO_BRANCH;
        e = sb.pop_front();
        check({tag, ".misp"}, r_mispredict, e.misp);
        check({tag, ".taken"}, r_taken, e.tk);
        if (e.fire) check({tag, ".redir"}, r_redirect_pc, e.redir);
    endtask

    task automatic resolve(input string tag, input logic [63:0] pc, input branch_t b,
                           input logic [63:0] a, input logic [63:0] c, input logic [63:0] tgt,
                           input logic pt, input logic [63:0] ptgt);
        drive_res(pc, b, a, c, tgt, pt, ptgt);
        @(negedge clk);
        check_res(tag);
    endtask

    task automatic pred(input string tag, input logic [63:0] pc, input logic t,
                        input logic [63:0] tgt);
        f_pc = pc;
        #1;
        check({tag, ".ptaken"}, f_pred_taken, t);
        check({tag, ".ptarget"}, f_pred_target, tgt);
    endtask

    task automatic count_init(input string tag, input bit mid_jump);
        int n = 0;
        logic [63:0] rpc;
        while (!ready && n < 200) begin
            if (n == 5) begin
                rpc = {$urandom, $urandom};
                pred({tag, ".init_pred"}, rpc, 1'b0, rpc + 64'd4);
            end
            if (mid_jump && n == 10) drive_res(64'h3000, J, 0, 0, 64'h7000, 1'b0, 0);
            if (mid_jump && n == 11) check_res({tag, ".midinit_j"});
            n++;
            @(negedge clk);
        end
        check({tag, ".init_cycles"}, n, 64);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst.ready", ready, 0);
        check("rst.misp", r_mispredict, 0);
        check("rst.taken", r_taken, 0);
        check("rst.redir", r_redirect_pc, 0);
        pred("rst", 64'h1234, 1'b0, 64'h1238);
        reset = 0;
        count_init("init", 1'b0);
        resolve("cold_bne", 64'h8000_0010, BRANCH_BNE, 1, 2, 64'h8000_0000, 1'b0, 0);
        pred("cold_bne", 64'h8000_0010, 1'b1, 64'h8000_0000);
        resolve("bge_alloc", 64'h8000_0100, BRANCH_BGE, 2, 1, 64'h8000_0400, 1'b0, 0);
        pred("bge_c2", 64'h8000_0100, 1'b1, 64'h8000_0400);
        resolve("bge_nt1", 64'h8000_0100, BRANCH_BGE, 1, 2, 64'h8000_0400, 1'b1, 64'h8000_0400);
        pred("bge_c1", 64'h8000_0100, 1'b0, 64'h8000_0104);
        resolve("bge_nt2", 64'h8000_0100, BRANCH_BGE, 1, 2, 64'h8000_0400, 1'b0, 0);
        resolve("bge_nt3", 64'h8000_0100, BRANCH_BGE, 1, 2, 64'h8000_0400, 1'b0, 0);
        pred("bge_c0", 64'h8000_0100, 1'b0, 64'h8000_0104);
        resolve("bge_t", 64'h8000_0100, BRANCH_BGE, 3, 3, 64'h8000_0400, 1'b0, 0);
        pred("bge_c1b", 64'h8000_0100, 1'b0, 64'h8000_0104);
        resolve("blt", 64'h200, BRANCH_BLT, '1, 0, 64'h100, 1'b0, 0);
        resolve("bltu", 64'h300, BRANCH_BLTU, '1, 0, 64'h100, 1'b0, 0);
        resolve("bgeu", 64'h320, BRANCH_BGEU, '1, 0, 64'h180, 1'b1, 64'h180);
        resolve("beq_wrap", 64'hFFFF_FFFF_FFFF_FFFC, BRANCH_BEQ, 5, 6, 64'h10, 1'b1, 64'h10);
        pred("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0);
        resolve("nobr", 64'h400, NO_BRANCH, 1, 1, 64'h500, 1'b1, 64'h500);
        pred("nobr", 64'h400, 1'b0, 64'h404);
        resolve("alias1", 64'h1040, J, 0, 0, 64'h5000, 1'b0, 0);
        pred("alias1", 64'h1040, 1'b1, 64'h5000);
        resolve("alias2", 64'h2040, J, 0, 0, 64'h6000, 1'b0, 0);
        pred("alias2", 64'h2040, 1'b1, 64'h6000);
        pred("alias1_evict", 64'h1040, 1'b0, 64'h1044);
        reset = 1;
        @(negedge clk);
        reset = 0;
        repeat (20) @(negedge clk);
        check("rst20.ready", ready, 0);
        reset = 1;
        @(negedge clk);
        reset = 0;
        count_init("reinit", 1'b1);
        pred("reinit_j", 64'h3000, 1'b0, 64'h3004);
        pred("reinit_cleared", 64'h8000_0010, 1'b0, 64'h8000_0014);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
